// File: rtl/digital_phase_shifter_multi.sv
// N-channel programmable phase shifter running on the 1280 MHz clock.
// A free-running phase counter spans one 40 MHz period; each channel emits
// a pulse of programmable start phase and width, with settings latched only
// at period boundaries so an update never produces a runt or split pulse.
`timescale 1ns/1ps
module digital_phase_shifter_multi #(
    parameter int unsigned NCH        = 2,
    parameter int unsigned PHASE_BITS = 5
) (
    input  logic                      clk1280,
    input  logic                      reset,
    input  logic                      sync,
    input  logic [NCH-1:0]            enable,
    input  logic [NCH-1:0]            invert,
    input  logic [NCH*PHASE_BITS-1:0] clockDelay,
    input  logic [NCH*PHASE_BITS-1:0] pulseWidth,
    output logic [NCH-1:0]            clkout,
    output logic [PHASE_BITS-1:0]     phase
);

    localparam int unsigned PW      = PHASE_BITS;
    localparam logic [PW-1:0] CNT_MAX = '1;

    logic [PW-1:0]     cnt;
    logic [NCH*PW-1:0] dly_q;
    logic [NCH*PW-1:0] wid_q;
    logic [NCH-1:0]    en_q;
    logic [NCH-1:0]    inv_q;
    logic [NCH-1:0]    hit_c;
    logic              load_c;

    // Settings load whenever the counter is about to become 0.
    assign load_c = sync | (cnt == CNT_MAX);

    // Phase counter: wraps modulo 2^PHASE_BITS, sync forces phase 0.
    always_ff @(posedge clk1280 or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (sync) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    // Shadow settings, captured only at the period boundary.
    always_ff @(posedge clk1280 or posedge reset) begin
        if (reset) begin
            dly_q <= '0;
            wid_q <= '0;
            en_q  <= '0;
            inv_q <= '0;
        end else if (load_c) begin
            dly_q <= clockDelay;
            wid_q <= pulseWidth;
            en_q  <= enable;
            inv_q <= invert;
        end
    end

    // Window test per channel; wrap subtraction keeps wrapped pulses contiguous.
    for (genvar i = 0; i < NCH; i++) begin : g_hit
        logic [PW-1:0] diff_c;
        assign diff_c   = cnt - dly_q[i*PW +: PW];
        assign hit_c[i] = (diff_c < wid_q[i*PW +: PW]);
    end

    // Registered channel outputs; a disabled channel is forced low.
    always_ff @(posedge clk1280 or posedge reset) begin
        if (reset) begin
            clkout <= '0;
        end else begin
            clkout <= en_q & (hit_c ^ inv_q);
        end
    end

    assign phase = cnt;

endmodule

// File: tb/tb_digital_phase_shifter_multi.sv
// Scoreboard bench for digital_phase_shifter_multi (NCH=2, PHASE_BITS=5).
// The stimulus thread pushes one expected {phase, clkout} per clock; the
// monitor pops and compares on every falling edge.
`timescale 1ns/1ps
module tb_digital_phase_shifter_multi;

    localparam int unsigned NCH = 2;
    localparam int unsigned PB  = 5;
    localparam int          P   = 32;

    logic              clk1280 = 1'b0;
    logic              reset;
    logic              sync;
    logic [NCH-1:0]    enable;
    logic [NCH-1:0]    invert;
    logic [NCH*PB-1:0] clockDelay;
    logic [NCH*PB-1:0] pulseWidth;
    logic [NCH-1:0]    clkout;
    logic [PB-1:0]     phase;

    typedef struct {
        logic [PB-1:0]  ph;
        logic [NCH-1:0] ck;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Bench view of the settings in force and of the phase counter.
    int   ep = 0;
    int   act_d   [NCH];
    int   act_w   [NCH];
    bit   act_en  [NCH];
    bit   act_inv [NCH];

    digital_phase_shifter_multi #(.NCH(NCH), .PHASE_BITS(PB)) dut (
        .clk1280    (clk1280),
        .reset      (reset),
        .sync       (sync),
        .enable     (enable),
        .invert     (invert),
        .clockDelay (clockDelay),
        .pulseWidth (pulseWidth),
        .clkout     (clkout),
        .phase      (phase)
    );

    always #2 clk1280 = ~clk1280;

    // Counter values for which the raw pulse is high: dly, dly+1, ... (w of them).
    function automatic logic [P-1:0] win(int d, int w);
        logic [P-1:0] m = '0;
        for (int k = 0; k < w; k++) m[(d + k) % P] = 1'b1;
        return m;
    endfunction

    task automatic clear_act();
        for (int c = 0; c < NCH; c++) begin
            act_d[c] = 0; act_w[c] = 0; act_en[c] = 0; act_inv[c] = 0;
        end
    endtask

    task automatic set_ch(int c, int d, int w, bit e, bit i);
        clockDelay[c*PB +: PB] = PB'(d);
        pulseWidth[c*PB +: PB] = PB'(w);
        enable[c] = e;
        invert[c] = i;
    endtask

    // One clock: capture what the DUT sees at the edge, then push its response.
    task automatic step();
        bit s, r;
        int sd [NCH]; int sw [NCH]; bit se [NCH]; bit si [NCH];
        exp_t e;
        logic [P-1:0] m;
        s = sync; r = reset;
        for (int c = 0; c < NCH; c++) begin
            sd[c] = int'(clockDelay[c*PB +: PB]);
            sw[c] = int'(pulseWidth[c*PB +: PB]);
            se[c] = enable[c];
            si[c] = invert[c];
        end
        @(posedge clk1280); #1;
        if (r) begin
            e.ck = '0;
            ep = 0;
            clear_act();
        end else begin
            for (int c = 0; c < NCH; c++) begin
                m = win(act_d[c], act_w[c]);
                e.ck[c] = act_en[c] ? (m[ep] ^ act_inv[c]) : 1'b0;
            end
            if (s || ep == P-1) begin
                for (int c = 0; c < NCH; c++) begin
                    act_d[c] = sd[c]; act_w[c] = sw[c];
                    act_en[c] = se[c]; act_inv[c] = si[c];
                end
            end
            ep = s ? 0 : (ep + 1) % P;
        end
        e.ph = PB'(ep);
        q.push_back(e);
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_to(int target);
        for (int k = 0; k < 2*P && ep != target; k++) step();
    endtask

    // Assert reset asynchronously just after an edge; outputs must clear at once.
    task automatic step_reset();
        exp_t e;
        @(posedge clk1280); #1;
        reset = 1'b1;
        ep = 0;
        clear_act();
        e.ph = '0;
        e.ck = '0;
        q.push_back(e);
    endtask

    // Monitor: every output sample is compared against the next expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk1280);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (phase !== e.ph) begin
                    errors++;
                    $display("FAIL phase t=%0t got=%0d want=%0d", $time, phase, e.ph);
                end
                checks++;
                if (clkout !== e.ck) begin
                    errors++;
                    $display("FAIL clkout t=%0t phase=%0d got=%b want=%b", $time, phase, clkout, e.ck);
                end
            end
        end
    end

    initial begin
        int dly_tab [7] = '{0, 1, 2, 3, 29, 30, 31};
        int wid_tab [9] = '{0, 1, 2, 3, 15, 16, 29, 30, 31};

        reset = 1'b1; sync = 1'b0;
        enable = '0; invert = '0; clockDelay = '0; pulseWidth = '0;
        clear_act();
        run(3);                         // reset state checked while held
        reset = 1'b0;

        // 50% clock on channel 0; channel 1 disabled with invert set
        set_ch(0, 0, 16, 1'b1, 1'b0);
        set_ch(1, 5, 7, 1'b0, 1'b1);
        run(3*P);

        // Delay sweep at width 16 (delay 29 wraps across rollover)
        foreach (dly_tab[k]) begin
            set_ch(0, dly_tab[k], 16, 1'b1, 1'b0);
            run(2*P);
        end

        // Width sweep at delay 0, including 0 and P-1
        foreach (wid_tab[k]) begin
            set_ch(0, 0, wid_tab[k], 1'b1, 1'b0);
            run(2*P);
        end

        // Mid-period change of channel 1 delay takes effect next period
        set_ch(0, 2, 9, 1'b1, 1'b0);
        set_ch(1, 0, 8, 1'b1, 1'b0);
        run(2*P);
        run_to(5);
        set_ch(1, 10, 8, 1'b1, 1'b0);
        run(2*P);

        // Sync at phase 17 with new settings; then sync held several cycles
        run_to(17);
        set_ch(0, 4, 12, 1'b1, 1'b0);
        sync = 1'b1;
        step();
        sync = 1'b0;
        run(P + 20);
        sync = 1'b1;
        run(5);
        sync = 1'b0;
        run(2*P);

        // Invert, disable at a boundary, re-enable, reset while output high
        set_ch(0, 3, 10, 1'b1, 1'b1);
        set_ch(1, 28, 6, 1'b1, 1'b0);
        run(2*P);
        run_to(15);
        set_ch(0, 3, 10, 1'b0, 1'b1);
        run(2*P);
        set_ch(0, 3, 10, 1'b1, 1'b1);
        run(2*P);
        run_to(20);
        step_reset();
        run(3);
        reset = 1'b0;
        run(2*P);

        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk1280);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digital_phase_shifter_multi.md
Name: digital_phase_shifter_multi

Overview:
- Parametrised N-channel successor to the two-channel 40 MHz digital phase shifter.
- Runs entirely on the 1280 MHz clock. A free-running phase counter (one 40 MHz period = 2^PHASE_BITS ticks) drives per-channel pulse generators, each with programmable start phase (delay) and width.
- New over the previous generation: any channel count, explicit 40 MHz re-alignment input, per-channel enable and invert, and glitch-free settings update at period boundaries.
- Feeds clock/strobe outputs to the readout and TDC logic.

Parameters:
- NCH, 2, number of output channels (1..16).
- PHASE_BITS, 5, phase counter width; period P = 2^PHASE_BITS ticks of clk1280.

Ports:
- clk1280  input  1  1280 MHz clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sync  input  1  re-alignment strobe, synchronous to clk1280; 1-cycle pulse marking the 40 MHz phase-0 tick.
- enable  input  NCH  per-channel enable.
- invert  input  NCH  per-channel output polarity inversion.
- clockDelay  input  NCH*PHASE_BITS  per-channel start phase; channel i at bits [i*PHASE_BITS +: PHASE_BITS].
- pulseWidth  input  NCH*PHASE_BITS  per-channel high width in ticks, same packing.
- clkout  output  NCH  shifted clock/pulse outputs.
- phase  output  PHASE_BITS  current phase counter value.

Behaviour:
Reset (async assert, sync release):
- cnt = 0.
- All shadow delay/width/enable/invert registers = 0.
- clkout = 0.
- The first settings load happens at the first boundary after release.

Phase counter:
- cnt increments by 1 modulo P each edge.
- If sync = 1 at an edge, cnt loads 0 instead of incrementing.
- phase = cnt.

Shadow load:
- Shadow registers capture clockDelay, pulseWidth, enable and invert at any edge where the next cnt is 0 (cnt == P-1 and no sync, or sync = 1).
- Between loads, input changes have no effect. This prevents runt or split pulses.

Per-channel pulse:
- Registered output, 1-cycle latency from cnt.
- Define hit_i = ((cnt - dly_i) mod P) < wid_i, computed with PHASE_BITS-bit unsigned wrap subtraction.
- At each edge, clkout[i] <= en_i ? (hit_i XOR inv_i) : 0.
- Result: clkout[i] is high for exactly wid_i consecutive cycles, starting the cycle after cnt == dly_i.

Boundary conditions:
- wid = 0: never high (constant inv_i while enabled).
- wid = P-1: high P-1 of P ticks.
- Pulses with dly + wid > P wrap across the period boundary and stay contiguous; there is no glitch at cnt rollover.
- Disabled channel outputs 0, ignoring invert. Enable/disable takes effect only at a boundary.
- sync arriving mid-period: cnt restarts at 0 and settings load. A pulse in progress is truncated or extended per the new phase; no other artefacts.
- Consecutive sync pulses every cycle hold cnt = 0.
- Reset mid-pulse: clkout drops to 0 immediately (async).

Test Plan:
- NCH=2, PHASE_BITS=5, delay=0, width=16, enable=1, invert=0, no sync -> clkout[0] is a 50% clock, period 32 cycles, rising the cycle after phase==0.
- Channel 0 delay swept 0,1,2,3,29,30,31 with width 16 -> rising edge moves by 1 tick per step. Delay 29: high for phases 29..31 and 0..12 (wrap), contiguous.
- Width swept 0,1,2,3,15,16,29,30,31 at delay 0 -> high-cycle counts 0,1,2,3,15,16,29,30,31 per period. Width 0 gives constant low.
- Change channel 1 delay 0->10 at phase 5 -> current period unchanged. New delay applies from the next period. No pulse shorter than the width.
- sync pulse asserted at phase 17 -> phase reads 0 next cycle. Settings load, and subsequent pulses are aligned to the new phase 0.
- invert=1, enable toggled, then reset asserted mid-high -> inverted waveform while enabled; 0 after disable at the boundary; clkout=0 and phase=0 immediately on reset.
